// File: rtl/alu_pkg.sv
// Shared types for the shared-ALU scheduler: ALU opcodes, slot state and datapath width.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101
  } alu_op_e;

  typedef enum logic {
    StEmpty,
    StFull
  } slot_e;

  function automatic logic is_legal_op(alu_op_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT};
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the client issue logic and the shared-ALU scheduler.
interface alu_rr_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  import alu_pkg::*;

  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [ALU_W*NREQ-1:0] req_a;
  logic [ALU_W*NREQ-1:0] req_b;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [ALU_W-1:0]      rsp_y;
  logic                  rsp_z;
  logic                  rsp_n;
  logic                  rsp_c;
  logic                  rsp_v;
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_z, rsp_n, rsp_c, rsp_v, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_z, rsp_n, rsp_c, rsp_v, rsp_err
  );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU. Unsupported opcodes yield y=0 with flags derived from that zero.
module alu
  import alu_pkg::*;
(
  input  alu_op_e          op,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] y,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v
);

  logic [ALU_W:0] sum_ext;
  logic [ALU_W:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  // Top bit of the widened difference is the borrow (a < b unsigned).
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        y = sum_ext[ALU_W-1:0];
        c = sum_ext[ALU_W];
        v = (a[ALU_W-1] == b[ALU_W-1]) && (y[ALU_W-1] != a[ALU_W-1]);
      end
      OP_SUB: begin
        y = diff_ext[ALU_W-1:0];
        c = diff_ext[ALU_W];
        v = (a[ALU_W-1] != b[ALU_W-1]) && (y[ALU_W-1] != a[ALU_W-1]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
    z = (y == '0);
    n = y[ALU_W-1];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found     = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU among NREQ requesters: round-robin grant, single result slot, valid/ready output.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_rr_scheduler_if.slave bus
);

  localparam int unsigned IDW = $clog2(NREQ);

  slot_e            slot_q, slot_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q;
  alu_op_e          op_q;
  logic [ALU_W-1:0] a_q, b_q;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic [2:0]       sel_op;
  logic [ALU_W-1:0] sel_a, sel_b;
  logic             pop, can_accept, accept;

  rr_arbiter #(
    .N(NREQ)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    pop        = (slot_q == StFull) && bus.rsp_ready;
    // rst_n gating keeps req_ready low for the whole reset window.
    can_accept = rst_n && ((slot_q == StEmpty) || pop);
    accept     = can_accept && (|bus.req_valid);

    slot_d = slot_q;
    unique case (slot_q)
      StEmpty: if (accept) slot_d = StFull;
      StFull:  if (pop && !accept) slot_d = StEmpty;
    endcase

    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_op = bus.req_op[3*i +: 3];
        sel_a  = bus.req_a[ALU_W*i +: ALU_W];
        sel_b  = bus.req_b[ALU_W*i +: ALU_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= StEmpty;
      ptr_q  <= '0;
    end else begin
      slot_q <= slot_d;
      ptr_q  <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_ADD;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= '0;
    end else if (accept) begin
      op_q <= alu_op_e'(sel_op);
      a_q  <= sel_a;
      b_q  <= sel_b;
      id_q <= gnt_idx;
    end
  end

  assign bus.req_ready = gnt & {NREQ{can_accept}};
  assign bus.rsp_valid = (slot_q == StFull);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_err   = ~is_legal_op(op_q);

  alu u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (bus.rsp_y),
    .z  (bus.rsp_z),
    .n  (bus.rsp_n),
    .c  (bus.rsp_c),
    .v  (bus.rsp_v)
  );

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: directed scenarios plus randomized traffic vs a reference model.
module tb_alu_rr_scheduler;

  localparam int unsigned NREQ = 4;

  typedef struct {
    int          id;
    logic [31:0] y;
    logic        z, n, c, v, err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_rr_scheduler_if #(.NREQ(NREQ)) bus ();

  alu_rr_scheduler #(
    .NREQ(NREQ)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [NREQ-1:0] vld = '0;
  logic [2:0]      op_arr [NREQ];
  logic [31:0]     a_arr  [NREQ];
  logic [31:0]     b_arr  [NREQ];
  logic            rsp_rdy = 1'b0;

  assign bus.req_valid = vld;
  assign bus.rsp_ready = rsp_rdy;
  for (genvar i = 0; i < NREQ; i++) begin : g_drv
    assign bus.req_op[3*i +: 3]  = op_arr[i];
    assign bus.req_a[32*i +: 32] = a_arr[i];
    assign bus.req_b[32*i +: 32] = b_arr[i];
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t exp_q[$];
  int   model_ptr = 0;
  bit   model_full = 1'b0;
  logic [NREQ-1:0] last_gnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin reference: first valid requester scanning from p with wraparound.
  function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic rsp_t model_alu(input int id, input logic [2:0] op,
                                     input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    longint sa, sb, ua, ub, wide;
    logic signed [31:0] ys;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r.id = id; r.y = '0; r.c = 1'b0; r.v = 1'b0; r.err = 1'b0;
    case (op)
      3'd0: begin
        r.y = a + b; wide = sa + sb; ys = r.y;
        r.c = ((ua + ub) >> 32) != 0;
        r.v = (wide != longint'(ys));
      end
      3'd1: begin
        r.y = a - b; wide = sa - sb; ys = r.y;
        r.c = (a < b);
        r.v = (wide != longint'(ys));
      end
      3'd2: r.y = a & b;
      3'd3: r.y = a | b;
      3'd4: r.y = a ^ b;
      3'd5: r.y = (sa < sb) ? 32'd1 : 32'd0;
      default: r.err = 1'b1;
    endcase
    r.z = (r.y == 32'd0);
    r.n = r.y[31];
    return r;
  endfunction

  // Issue side: predicts req_ready/rsp_valid and queues the expected response for each accept.
  initial begin : watcher
    int g;
    bit pop, can;
    logic [NREQ-1:0] er;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        model_ptr  = 0;
        model_full = 1'b0;
        exp_q.delete();
        last_gnt   = '0;
      end else begin
        g   = model_grant(vld, model_ptr);
        pop = model_full && rsp_rdy;
        can = !model_full || pop;
        er  = (g >= 0 && can) ? (NREQ'(1) << g) : '0;
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(model_full));
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        last_gnt = bus.req_ready;
        if (er != '0) begin
          exp_q.push_back(model_alu(g, op_arr[g], a_arr[g], b_arr[g]));
          model_ptr  = (g + 1) % NREQ;
          model_full = 1'b1;
        end else if (pop) begin
          model_full = 1'b0;
        end
      end
    end
  end

  // Response side: pops on every handshake and checks stability under backpressure.
  initial begin : monitor
    rsp_t e;
    logic [63:0] cur, held;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && bus.rsp_valid) begin
        cur = {25'd0, bus.rsp_id, bus.rsp_y, bus.rsp_z, bus.rsp_n, bus.rsp_c, bus.rsp_v,
               bus.rsp_err};
        if (stalled) chk("rsp_hold_stable", cur, held);
        if (rsp_rdy) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_unexpected: got response id %0d, expected none queued",
                     bus.rsp_id);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
            chk("rsp_y", 64'(bus.rsp_y), 64'(e.y));
            chk("rsp_flags_znvc_err",
                64'({bus.rsp_z, bus.rsp_n, bus.rsp_c, bus.rsp_v, bus.rsp_err}),
                64'({e.z, e.n, e.c, e.v, e.err}));
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
        end
        held = cur;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    vld[i] = 1'b1; op_arr[i] = op; a_arr[i] = a; b_arr[i] = b;
  endtask

  // Issue one lone request on an empty slot; returns the response seen the next cycle.
  task automatic single(input int i, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] y, output logic [4:0] f);
    @(negedge clk);
    set_req(i, op, a, b);
    rsp_rdy = 1'b1;
    @(negedge clk);
    vld[i] = 1'b0;
    #3;
    y = bus.rsp_y;
    f = {bus.rsp_z, bus.rsp_n, bus.rsp_c, bus.rsp_v, bus.rsp_err};
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin : stimulus
    logic [31:0] y;
    logic [4:0]  f;
    for (int i = 0; i < NREQ; i++) begin
      op_arr[i] = '0; a_arr[i] = '0; b_arr[i] = '0;
    end

    // Reset state, with every requester asking so a leaky req_ready would show.
    vld = '1;
    #12;
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_y", 64'(bus.rsp_y), 64'd0);
    chk("reset_flags", 64'({bus.rsp_z, bus.rsp_n, bus.rsp_c, bus.rsp_v, bus.rsp_err}),
        64'(5'b10000));
    @(negedge clk);
    vld = '0;
    rst_n = 1'b1;

    // Single ADD from requester 0.
    set_req(0, 3'd0, 32'd5, 32'd3);
    rsp_rdy = 1'b1;
    #3;
    chk("t1_req_ready", 64'(bus.req_ready), 64'(4'b0001));
    @(negedge clk);
    vld[0] = 1'b0;
    #3;
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t1_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("t1_rsp_y", 64'(bus.rsp_y), 64'd8);
    chk("t1_flags", 64'({bus.rsp_z, bus.rsp_n, bus.rsp_c, bus.rsp_v}), 64'd0);

    // Backpressure: result pending, requesters 1 and 2 blocked for three cycles.
    @(negedge clk);
    set_req(0, 3'd0, 32'd1, 32'd1);
    rsp_rdy = 1'b0;
    @(negedge clk);
    vld[0] = 1'b0;
    set_req(1, 3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
    set_req(2, 3'd4, 32'h1234_5678, 32'h1111_1111);
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("t3_blocked_ready", 64'(bus.req_ready), 64'd0);
      chk("t3_pending_y", 64'(bus.rsp_y), 64'd2);
      @(negedge clk);
    end
    rsp_rdy = 1'b1;
    #3;
    chk("t3_pop_accept_ready", 64'(bus.req_ready), 64'(4'b0010));
    @(negedge clk);
    vld[1] = 1'b0;
    #3;
    chk("t3_next_id", 64'(bus.rsp_id), 64'd1);
    @(negedge clk);
    vld[2] = 1'b0;
    #3;
    chk("t3_third_id", 64'(bus.rsp_id), 64'd2);
    @(negedge clk);

    // Flags and boundary results.
    single(1, 3'd1, 32'h0, 32'h1, y, f);
    chk("t4_sub_y", 64'(y), 64'hFFFF_FFFF);
    chk("t4_sub_flags", 64'(f), 64'(5'b01100));
    single(2, 3'd0, 32'h7FFF_FFFF, 32'h1, y, f);
    chk("t4_add_ovf_y", 64'(y), 64'h8000_0000);
    chk("t4_add_ovf_flags", 64'(f), 64'(5'b01010));
    single(3, 3'd5, 32'hFFFF_FFFF, 32'h0, y, f);
    chk("t4_slt_y", 64'(y), 64'd1);

    // Unsupported opcode is still answered, then normal service resumes.
    single(0, 3'd7, 32'hAAAA_5555, 32'hAAAA_5555, y, f);
    chk("t5_illegal_y", 64'(y), 64'd0);
    chk("t5_illegal_flags", 64'(f), 64'(5'b10001));
    single(0, 3'd0, 32'd2, 32'd3, y, f);
    chk("t5_after_y", 64'(y), 64'd5);
    chk("t5_after_flags", 64'(f), 64'd0);

    // All requesters valid from reset: strict 0,1,2,3,0,1 rotation.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_rdy = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'($urandom_range(0, 5)), $urandom, $urandom);
    for (int k = 0; k < 6; k++) begin
      #3;
      chk("t2_grant", 64'(bus.req_ready), 64'(NREQ'(1) << (k % NREQ)));
      if (k > 0) chk("t2_rsp_id", 64'(bus.rsp_id), 64'((k - 1) % NREQ));
      @(negedge clk);
      set_req(k % NREQ, 3'($urandom_range(0, 5)), $urandom, $urandom);
    end
    vld = '0;
    repeat (2) @(negedge clk);

    // Reset while a result is pending and the pointer sits at 2.
    set_req(1, 3'd0, 32'd10, 32'd20);
    rsp_rdy = 1'b0;
    @(negedge clk);
    vld[1] = 1'b0;
    #1;
    chk("t6_pending_before_reset", 64'(bus.rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rsp_valid_async_drop", 64'(bus.rsp_valid), 64'd0);
    vld = '1;
    #1;
    chk("t6_ready_in_reset", 64'(bus.req_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_rdy = 1'b1;
    #3;
    chk("t6_first_grant", 64'(bus.req_ready), 64'(4'b0001));
    @(negedge clk);
    vld = '0;
    repeat (2) @(negedge clk);

    // Randomized traffic; a pending request holds until it is granted.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_gnt[i]) vld[i] = 1'b0;
        if (!vld[i] && $urandom_range(0, 2) == 0) begin
          set_req(i, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
        end
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    for (int i = 0; i < NREQ; i++) if (last_gnt[i]) vld[i] = 1'b0;
    // Let outstanding requests finish before draining.
    rsp_rdy = 1'b1;
    for (int cyc = 0; cyc < 20 && vld != '0; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (last_gnt[i]) vld[i] = 1'b0;
    end
    chk("drain_requests_served", 64'(vld), 64'd0);
    vld = '0;
    repeat (3) @(negedge clk);
    #5;
    chk("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
